// File: rtl/note_stack.sv
// Last-note-priority held-key stack feeding one envelope channel's trigger inputs.
// Optional sustain-pedal handling (release marking + PURGE) is built when NOTE_STACK_SUSTAIN_EN is defined.
module note_stack #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_vel,
    input  logic       sustain,
    output logic       note_on,
    output logic [6:0] note_start,
    output logic [6:0] vel_start,
    output logic       note_repeat,
    output logic [2:0] dbg_state
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_UPDATE = 3'd2,
        S_OUT    = 3'd3
`ifdef NOTE_STACK_SUSTAIN_EN
        ,
        S_PURGE  = 3'd4
`endif
    } state_t;

    state_t          r_state;
    logic [6:0]      r_note [DEPTH];
    logic [6:0]      r_vel  [DEPTH];
    logic            r_rel  [DEPTH];
    logic [CW-1:0]   r_count;
    logic [IW-1:0]   r_idx;
    logic            r_hit;
    logic [IW-1:0]   r_hit_idx;
    logic [6:0]      r_ev_note;
    logic [6:0]      r_ev_vel;
    logic            r_is_on;
    logic            r_top_vld;
    logic [6:0]      r_top_note;

    logic [IW-1:0]   w_top_idx;
    logic            w_rm_en;
    logic [IW-1:0]   w_rm_idx;
    logic            w_push;
    logic            w_set_rel;
    logic [CW-1:0]   w_rm_count;
    logic [6:0]      w_rm_note [DEPTH];
    logic [6:0]      w_rm_vel  [DEPTH];
    logic            w_rm_rel  [DEPTH];
    logic            w_purge_req;

`ifdef NOTE_STACK_SUSTAIN_EN
    logic            r_ev_sus;
    logic            r_sus_d;
    logic            r_pend;
    logic [CW-1:0]   r_wp;
    logic            w_sus_fall;
    logic            w_keep;

    assign w_sus_fall  = r_sus_d & ~sustain;
    assign w_purge_req = r_pend | w_sus_fall;
    assign w_keep      = ({1'b0, r_idx} < r_count) && !r_rel[r_idx];
`else
    logic            w_unused_sustain;

    assign w_unused_sustain = sustain;
    assign w_purge_req      = 1'b0;
`endif

    assign w_top_idx = IW'(r_count - CW'(1));
    assign ev_ready  = (r_state == S_IDLE) && !w_purge_req;
    assign dbg_state = r_state;

    // Removal (match or full-stack drop of index 0) is computed first; the push lands on top of the result.
    always_comb begin
        w_rm_en   = 1'b0;
        w_rm_idx  = r_hit_idx;
        w_push    = 1'b0;
        w_set_rel = 1'b0;
        if (r_is_on) begin
            w_push = 1'b1;
            if (r_hit) begin
                w_rm_en = 1'b1;
            end else if (r_count == CW'(DEPTH)) begin
                w_rm_en  = 1'b1;
                w_rm_idx = '0;
            end
        end else if (r_hit) begin
`ifdef NOTE_STACK_SUSTAIN_EN
            if (r_ev_sus) w_set_rel = 1'b1;
            else          w_rm_en   = 1'b1;
`else
            w_rm_en = 1'b1;
`endif
        end
        w_rm_count = w_rm_en ? r_count - CW'(1) : r_count;
        for (int j = 0; j < DEPTH; j++) begin
            w_rm_note[j] = r_note[j];
            w_rm_vel[j]  = r_vel[j];
            w_rm_rel[j]  = r_rel[j];
        end
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (w_rm_en && (IW'(j) >= w_rm_idx)) begin
                w_rm_note[j] = r_note[j+1];
                w_rm_vel[j]  = r_vel[j+1];
                w_rm_rel[j]  = r_rel[j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            r_ev_note   <= '0;
            r_ev_vel    <= '0;
            r_is_on     <= 1'b0;
            r_top_vld   <= 1'b0;
            r_top_note  <= '0;
            note_on     <= 1'b0;
            note_start  <= '0;
            vel_start   <= '0;
            note_repeat <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                r_note[j] <= '0;
                r_vel[j]  <= '0;
                r_rel[j]  <= 1'b0;
            end
`ifdef NOTE_STACK_SUSTAIN_EN
            r_ev_sus    <= 1'b0;
            r_sus_d     <= 1'b0;
            r_pend      <= 1'b0;
            r_wp        <= '0;
`endif
        end else if (en) begin
            note_repeat <= 1'b0;
`ifdef NOTE_STACK_SUSTAIN_EN
            r_sus_d <= sustain;
            if (r_state != S_IDLE && w_sus_fall) r_pend <= 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
`ifdef NOTE_STACK_SUSTAIN_EN
                    if (w_purge_req) begin
                        r_pend  <= 1'b0;
                        r_idx   <= '0;
                        r_wp    <= '0;
                        r_is_on <= 1'b0;
                        r_state <= S_PURGE;
                    end else
`endif
                    if (ev_valid && ev_ready) begin
                        r_ev_note  <= ev_note;
                        r_ev_vel   <= ev_vel;
                        r_is_on    <= ev_on && (ev_vel != 7'd0);
                        r_top_vld  <= (r_count != '0);
                        r_top_note <= r_note[w_top_idx];
                        r_idx      <= '0;
                        r_hit      <= 1'b0;
`ifdef NOTE_STACK_SUSTAIN_EN
                        r_ev_sus   <= sustain;
`endif
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!r_hit && ({1'b0, r_idx} < r_count) && (r_note[r_idx] == r_ev_note)) begin
                        r_hit     <= 1'b1;
                        r_hit_idx <= r_idx;
                    end
                    if (r_idx == IW'(DEPTH - 1)) r_state <= S_UPDATE;
                    else                         r_idx   <= r_idx + IW'(1);
                end
                S_UPDATE: begin
                    for (int j = 0; j < DEPTH; j++) begin
                        r_note[j] <= w_rm_note[j];
                        r_vel[j]  <= w_rm_vel[j];
                        r_rel[j]  <= w_rm_rel[j];
                    end
                    if (w_push) begin
                        r_note[IW'(w_rm_count)] <= r_ev_note;
                        r_vel[IW'(w_rm_count)]  <= r_ev_vel;
                        r_rel[IW'(w_rm_count)]  <= 1'b0;
                    end
                    if (w_set_rel) r_rel[r_hit_idx] <= 1'b1;
                    r_count <= w_rm_count + CW'(w_push);
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    note_on     <= (r_count != '0);
                    note_start  <= (r_count != '0) ? r_note[w_top_idx] : 7'd0;
                    vel_start   <= (r_count != '0) ? r_vel[w_top_idx]  : 7'd0;
                    note_repeat <= r_is_on && r_top_vld && (r_ev_note == r_top_note);
                    r_state     <= S_IDLE;
                end
`ifdef NOTE_STACK_SUSTAIN_EN
                // In-place compaction: the write pointer never passes the read index.
                S_PURGE: begin
                    if (w_keep) begin
                        r_note[IW'(r_wp)] <= r_note[r_idx];
                        r_vel[IW'(r_wp)]  <= r_vel[r_idx];
                        r_rel[IW'(r_wp)]  <= 1'b0;
                    end
                    r_wp <= r_wp + CW'(w_keep);
                    if (r_idx == IW'(DEPTH - 1)) begin
                        r_count <= r_wp + CW'(w_keep);
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
